// File: rtl/mem_bus_pkg.sv
// Shared IO-bus memory map, sequencer state encoding and SRAM read pipeline default.
// Also consumed by the SRAM interface address decode.
package mem_bus_pkg;

    localparam logic [31:0] BEGINNING_SRAM       = 32'h1001_0000;
    localparam logic [31:0] END_SRAM             = 32'h101F_FFFF;
    localparam int unsigned READ_LATENCY_DEFAULT = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        ACK  = 2'd3
    } busState_t;

endpackage

// File: rtl/sram_addr_decode.sv
// Combinational SRAM window decode: inclusive byte-address compare against the SRAM bounds.
// Zero latency; no flow control.
module sram_addr_decode
    import mem_bus_pkg::*;
(
    input  logic [31:0] address,
    output logic        inRange
);

    assign inRange = (address >= BEGINNING_SRAM) && (address <= END_SRAM);

endmodule

// File: rtl/sram_bus_sequencer.sv
// Turns single-cycle processor requests into timed SRAM bus windows and returns done/read data.
// Write: done 2 cycles after accept; read: done READ_LATENCY+2 cycles after accept. Requests while busy are dropped.
module sram_bus_sequencer
    import mem_bus_pkg::*;
#(
    parameter int unsigned READ_LATENCY = READ_LATENCY_DEFAULT
)
(
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iReq,
    input  logic        iWrite,
    input  logic [3:0]  iByteEnable,
    input  logic [31:0] iAddress,
    input  logic [31:0] iWriteData,
    output logic        oBusy,
    output logic        oDone,
    output logic [31:0] oReadData,
    output logic        oError,
    output logic        oReadEnable,
    output logic        oWriteEnable,
    output logic [3:0]  oByteEnable,
    output logic [31:0] oAddress,
    output logic [31:0] oWriteData,
    input  logic [31:0] iReadData
);

    localparam logic [2:0] LATENCY = 3'(READ_LATENCY);

    busState_t  state;
    busState_t  nextState;
    logic [2:0] count;
    logic       errFlag;
    logic       inRange;
    logic       accept;

    sram_addr_decode uDecode (
        .address (iAddress),
        .inRange (inRange)
    );

    // ACK doubles as an accept slot so back-to-back requests lose no cycle.
    assign accept = iReq && ((state == IDLE) || (state == ACK));

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE, ACK: begin
                if (accept) begin
                    if (!inRange) begin
                        nextState = ACK;
                    end else if (iWrite) begin
                        nextState = WR;
                    end else begin
                        nextState = RD;
                    end
                end else begin
                    nextState = IDLE;
                end
            end
            WR:      nextState = ACK;
            RD:      nextState = (count == 3'd0) ? ACK : RD;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            count       <= 3'd0;
            errFlag     <= 1'b0;
            oByteEnable <= 4'd0;
            oAddress    <= 32'd0;
            oWriteData  <= 32'd0;
            oReadData   <= 32'd0;
        end else if (accept) begin
            count       <= LATENCY;
            errFlag     <= !inRange;
            oByteEnable <= iWrite ? iByteEnable : 4'b1111;
            oAddress    <= {iAddress[31:2], 2'b00};
            oWriteData  <= iWriteData;
            if (!inRange) begin
                oReadData <= 32'd0;
            end
        end else if (state == RD) begin
            if (count == 3'd0) begin
                oReadData <= iReadData;
            end else begin
                count <= count - 3'd1;
            end
        end
    end

    always_comb begin
        oBusy        = (state == WR) || (state == RD);
        oDone        = (state == ACK);
        oError       = (state == ACK) && errFlag;
        oReadEnable  = (state == RD);
        // A write with no byte lanes still takes its window but never strobes the SRAM.
        oWriteEnable = (state == WR) && (oByteEnable != 4'd0);
    end

endmodule
